// File: rtl/result_buffer.sv
// Result FIFO between the calculator core and its consumer: first-word-fall-through
// output with a valid/ready handshake, plus sticky overflow and a saturating drop counter.
module result_buffer #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1),
  parameter int DROP_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  In_Valid,
  input  logic [DATA_WIDTH-1:0] In_Result,
  input  logic                  Out_Ready,
  output logic                  Out_Valid,
  output logic [DATA_WIDTH-1:0] Out_Result,
  output logic [CNT_WIDTH-1:0]  Count,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Overflow,
  output logic [DROP_WIDTH-1:0] Drop_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  push;
  logic                  pop;
  logic                  drop;

  function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
    return (&v) ? v : v + DROP_WIDTH'(1);
  endfunction

  // Status comes only from the registered count, so inputs never reach outputs combinationally.
  assign Full       = (Count == FULL_CNT);
  assign Empty      = (Count == '0);
  assign Out_Valid  = !Empty;
  assign Out_Result = Empty ? '0 : mem[rd_ptr];

  assign pop  = Out_Valid && Out_Ready;
  assign push = In_Valid && (!Full || pop);
  assign drop = In_Valid && Full && !pop;

  // Storage is deliberately left unreset; only pointers and counters carry state.
  always_ff @(posedge CLK) begin
    if (push && !Flush)
      mem[wr_ptr] <= In_Result;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      Count      <= '0;
      Overflow   <= 1'b0;
      Drop_Count <= '0;
    end else if (Flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      Count      <= '0;
      Overflow   <= 1'b0;
      Drop_Count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   Count <= Count + CNT_WIDTH'(1);
        2'b01:   Count <= Count - CNT_WIDTH'(1);
        default: Count <= Count;
      endcase
      if (drop) begin
        Overflow   <= 1'b1;
        Drop_Count <= sat_inc(Drop_Count);
      end
    end
  end

endmodule

// File: tb/tb_result_buffer.sv
// Bench for result_buffer: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer's observable behaviour.
module tb_result_buffer;

  localparam int DATA_WIDTH = 18;
  localparam int DEPTH      = 8;
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);
  localparam int DROP_WIDTH = 8;
  localparam int DROP_MAX   = (1 << DROP_WIDTH) - 1;

  logic                  CLK = 1'b0;
  logic                  Reset = 1'b0;
  logic                  Flush = 1'b0;
  logic                  In_Valid = 1'b0;
  logic [DATA_WIDTH-1:0] In_Result = '0;
  logic                  Out_Ready = 1'b0;
  logic                  Out_Valid;
  logic [DATA_WIDTH-1:0] Out_Result;
  logic [CNT_WIDTH-1:0]  Count;
  logic                  Full;
  logic                  Empty;
  logic                  Overflow;
  logic [DROP_WIDTH-1:0] Drop_Count;

  result_buffer #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH), .DROP_WIDTH(DROP_WIDTH)
  ) dut (
    .CLK(CLK), .Reset(Reset), .Flush(Flush), .In_Valid(In_Valid), .In_Result(In_Result),
    .Out_Ready(Out_Ready), .Out_Valid(Out_Valid), .Out_Result(Out_Result), .Count(Count),
    .Full(Full), .Empty(Empty), .Overflow(Overflow), .Drop_Count(Drop_Count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents in arrival order, sticky flag, saturating drop tally.
  int q[$];
  bit m_ovf   = 1'b0;
  int m_drops = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"}, 32'(Count), n);
    check({tag, ".empty"}, 32'(Empty), (n == 0) ? 1 : 0);
    check({tag, ".full"}, 32'(Full), (n == DEPTH) ? 1 : 0);
    check({tag, ".valid"}, 32'(Out_Valid), (n != 0) ? 1 : 0);
    check({tag, ".data"}, 32'(Out_Result), (n != 0) ? q[0] : 0);
    check({tag, ".ovf"}, 32'(Overflow), 32'(m_ovf));
    check({tag, ".drops"}, 32'(Drop_Count), m_drops);
  endtask

  // One clock: compare current outputs, apply inputs, advance model, step to next negedge.
  task automatic cycle(input logic v, input int d, input logic r, input logic f);
    bit was_full, do_pop, do_push;
    check_all("cyc");
    In_Valid  = v;
    In_Result = d[DATA_WIDTH-1:0];
    Out_Ready = r;
    Flush     = f;
    was_full = (q.size() == DEPTH);
    do_pop   = (q.size() != 0) && r;
    do_push  = v && (!was_full || do_pop);
    if (f) begin
      model_clear();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d & ((1 << DATA_WIDTH) - 1));
      if (v && was_full && !do_pop) begin
        m_ovf = 1'b1;
        if (m_drops < DROP_MAX) m_drops++;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    In_Valid = 1'b0;
    Out_Ready = 1'b0;
    Flush = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check_all("reset");
    check("reset.empty_k", 32'(Empty), 1);
    Reset = 1'b1;
    @(negedge CLK);

    // Three results held, then drained in order.
    cycle(1, 5, 0, 0); cycle(1, 6, 0, 0); cycle(1, 7, 0, 0);
    check("t1.count", 32'(Count), 3);
    check("t1.head", 32'(Out_Result), 5);
    for (int i = 5; i <= 7; i++) begin
      check("t1.drain", 32'(Out_Result), i);
      cycle(0, 0, 1, 0);
    end
    check("t1.empty", 32'(Empty), 1);

    // Fill, one dropped push, drain.
    for (int i = 1; i <= 8; i++) cycle(1, i, 0, 0);
    check("t2.full", 32'(Full), 1);
    cycle(1, 9, 0, 0);
    check("t2.ovf", 32'(Overflow), 1);
    check("t2.drops", 32'(Drop_Count), 1);
    for (int i = 1; i <= 8; i++) begin
      check("t2.drain", 32'(Out_Result), i);
      cycle(0, 0, 1, 0);
    end
    check("t2.empty", 32'(Empty), 1);

    // Full with simultaneous push and pop: no drop, new value exits last.
    for (int i = 1; i <= 8; i++) cycle(1, i, 0, 0);
    cycle(1, 100, 1, 0);
    check("t3.count", 32'(Count), 8);
    check("t3.drops", 32'(Drop_Count), 1);
    for (int i = 2; i <= 9; i++) begin
      check("t3.drain", 32'(Out_Result), (i == 9) ? 100 : i);
      cycle(0, 0, 1, 0);
    end

    // Streaming through a single slot, wrapping pointers.
    cycle(1, 0, 1, 0);
    for (int i = 1; i < 20; i++) begin
      check("t4.count", 32'(Count), 1);
      check("t4.data", 32'(Out_Result), i - 1);
      cycle(1, i, 1, 0);
    end
    check("t4.last", 32'(Out_Result), 19);
    cycle(0, 0, 1, 0);
    check("t4.empty", 32'(Empty), 1);

    // Drop counter saturation, then flush with concurrent traffic.
    for (int i = 0; i < 8; i++) cycle(1, 200 + i, 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, i, 0, 0);
    check("t5.sat", 32'(Drop_Count), 255);
    cycle(1, 55, 1, 1);
    check("t5.count", 32'(Count), 0);
    check("t5.ovf", 32'(Overflow), 0);
    check("t5.drops", 32'(Drop_Count), 0);
    check("t5.data", 32'(Out_Result), 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) cycle(1, 40 + i, 0, 0);
    check("t6.pre", 32'(Count), 4);
    Reset = 1'b0;
    #3;
    check("t6.count", 32'(Count), 0);
    check("t6.valid", 32'(Out_Valid), 0);
    check("t6.data", 32'(Out_Result), 0);
    model_clear();
    #1;
    Reset = 1'b1;
    @(negedge CLK);
    cycle(1, 77, 0, 0);
    check("t6.push", 32'(Count), 1);
    check("t6.head", 32'(Out_Result), 77);

    // Random traffic with bursty readiness and rare flushes.
    for (int i = 0; i < 600; i++) begin
      logic v, r, f;
      v = ($urandom_range(0, 3) != 0);
      r = (((i / 50) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 79) == 0);
      cycle(v, int'($urandom_range(0, (1 << DATA_WIDTH) - 1)), r, f);
    end
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
